// File: rtl/jtag_loopback_tester_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : selftest_pkg                                                  |
// | Description : Shared types and constants for the JTAG loopback self-test:  |
// |               FSM state enum, lane width, pattern count and pattern ROM.   |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package selftest_pkg;

  localparam int LANES        = 4;
  localparam int NUM_PATTERNS = 10;
  localparam int IDX_W        = 4;

  typedef logic [LANES-1:0] lane_t;

  // Walking one, walking zero, then all-low and all-high.
  localparam lane_t PATTERN_ROM [NUM_PATTERNS] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000,
    4'b1110, 4'b1101, 4'b1011, 4'b0111,
    4'b0000, 4'b1111
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage : selftest_pkg
`default_nettype wire

// File: rtl/jtag_loopback_tester_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : jtag_loopback_tester_if                                       |
// | Description : Host/loopback-side signal bundle of the self-test sequencer. |
// |               err_count exists only when SELFTEST_ERRCNT_EN is defined.    |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface jtag_loopback_tester_if;
  import selftest_pkg::*;

  logic              start;
  logic [LANES-1:0]  jtag_in;
  logic [LANES-1:0]  jtag_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [LANES-1:0]  fail_lanes;
`ifdef SELFTEST_ERRCNT_EN
  logic [7:0]        err_count;
`endif

  // Host side: requests runs, closes the loopback, reads status.
  modport master (
    output start, jtag_in,
`ifdef SELFTEST_ERRCNT_EN
    input  err_count,
`endif
    input  jtag_out, busy, done, pass, fail_lanes
  );

  // Sequencer side.
  modport slave (
    input  start, jtag_in,
`ifdef SELFTEST_ERRCNT_EN
    output err_count,
`endif
    output jtag_out, busy, done, pass, fail_lanes
  );

endinterface : jtag_loopback_tester_if
`default_nettype wire

// File: rtl/jtag_loopback_tester_sync2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync2                                                         |
// | Description : Parameterised-width two-flop synchroniser, async active-low  |
// |               reset to zero.                                               |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops to resolve metastability of the async input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync2
`default_nettype wire

// File: rtl/jtag_loopback_tester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : jtag_loopback_tester                                          |
// | Description : Drives the pattern ROM onto the JTAG lines, samples the       |
// |               looped-back lines after SETTLE_CYCLES and accumulates sticky |
// |               per-lane mismatch flags over PASSES sequences.               |
// |               Optional macro SELFTEST_ERRCNT_EN adds a saturating 8-bit    |
// |               count of mismatching SAMPLE cycles (err_count).              |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module jtag_loopback_tester
  import selftest_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int PASSES        = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  jtag_loopback_tester_if.slave bus
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PASS_W   = (PASSES > 1) ? $clog2(PASSES) : 1;

  localparam logic [SETTLE_W-1:0] c_settle_last = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [PASS_W-1:0]   c_pass_last   = PASS_W'(PASSES - 1);
  localparam logic [IDX_W-1:0]    c_idx_last    = IDX_W'(NUM_PATTERNS - 1);

  // Synchronised inputs
  logic             start_sync;
  logic [LANES-1:0] jtag_sync;
  logic             start_prev_q;
  logic             start_edge;

  // FSM and counters
  state_e                state_q,    state_d;
  logic [IDX_W-1:0]      index_q,    index_d;
  logic [PASS_W-1:0]     pass_cnt_q, pass_cnt_d;
  logic [SETTLE_W-1:0]   settle_q,   settle_d;

  // Status registers
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [LANES-1:0]      fail_q, fail_d;
  logic [LANES-1:0]      mismatch;

`ifdef SELFTEST_ERRCNT_EN
  logic [7:0]            err_q, err_d;
`else
  // No error counter in this build.
`endif

  sync2 #(.WIDTH(1)) u_sync_start (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.start),
    .q_o   (start_sync)
  );

  sync2 #(.WIDTH(LANES)) u_sync_jtag (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.jtag_in),
    .q_o   (jtag_sync)
  );

  // Edges seen while not in IDLE are consumed here and lost, so a held or
  // re-toggled start during a run cannot restart or extend it.
  assign start_edge = start_sync & ~start_prev_q;
  assign mismatch   = jtag_sync ^ PATTERN_ROM[index_q];

  // State, counter and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_prev_q <= 1'b0;
      state_q      <= ST_IDLE;
      index_q      <= '0;
      pass_cnt_q   <= '0;
      settle_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= '0;
`ifdef SELFTEST_ERRCNT_EN
      err_q        <= '0;
`endif
    end else begin
      start_prev_q <= start_sync;
      state_q      <= state_d;
      index_q      <= index_d;
      pass_cnt_q   <= pass_cnt_d;
      settle_q     <= settle_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
`ifdef SELFTEST_ERRCNT_EN
      err_q        <= err_d;
`endif
    end
  end

  // Next-state and register updates; status changes become visible the cycle
  // after the state that decides them.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    pass_cnt_d = pass_cnt_q;
    settle_d   = settle_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
`ifdef SELFTEST_ERRCNT_EN
    err_d      = err_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          done_d     = 1'b0;
          pass_d     = 1'b0;
          fail_d     = '0;
          busy_d     = 1'b1;
          index_d    = '0;
          pass_cnt_d = '0;
          settle_d   = '0;
`ifdef SELFTEST_ERRCNT_EN
          err_d      = '0;
`endif
          state_d    = ST_DRIVE;
        end
      end

      ST_DRIVE: begin
        if (settle_q == c_settle_last) begin
          settle_d = '0;
          state_d  = ST_SAMPLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      ST_SAMPLE: begin
        fail_d = fail_q | mismatch;
`ifdef SELFTEST_ERRCNT_EN
        if ((mismatch != '0) && (err_q != 8'hFF)) begin
          err_d = err_q + 8'd1;
        end
`endif
        if (index_q != c_idx_last) begin
          index_d = index_q + 1'b1;
          state_d = ST_DRIVE;
        end else if (pass_cnt_q != c_pass_last) begin
          pass_cnt_d = pass_cnt_q + 1'b1;
          index_d    = '0;
          state_d    = ST_DRIVE;
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (fail_q == '0);
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Pattern is held through the SAMPLE cycle; lines are parked low otherwise.
  always_comb begin
    bus.jtag_out = '0;
    if ((state_q == ST_DRIVE) || (state_q == ST_SAMPLE)) begin
      bus.jtag_out = PATTERN_ROM[index_q];
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.fail_lanes = fail_q;
`ifdef SELFTEST_ERRCNT_EN
  assign bus.err_count  = err_q;
`endif

endmodule : jtag_loopback_tester
`default_nettype wire

// File: tb/tb_jtag_loopback_tester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_jtag_loopback_tester                                       |
// | Description : Two sequencer instances (defaults, and PASSES=3 with         |
// |               SETTLE_CYCLES=2) behind injectable loopback faults, checked  |
// |               every cycle against a run-position model. Honours            |
// |               SELFTEST_ERRCNT_EN for err_count.                            |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_jtag_loopback_tester;

  localparam logic [3:0] ROM_M [10] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1110,
    4'b1101, 4'b1011, 4'b0111, 4'b0000, 4'b1111
  };

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  jtag_loopback_tester_if u_if0 ();
  jtag_loopback_tester_if u_if1 ();

  jtag_loopback_tester #(.SETTLE_CYCLES(4), .PASSES(1)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if0)
  );

  jtag_loopback_tester #(.SETTLE_CYCLES(2), .PASSES(3)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if1)
  );

  // Loopback plug with one cycle of delay and injectable faults.
  logic [3:0] lb0_q = '0;
  logic [3:0] lb1_q = '0;
  logic [3:0] andm [2];
  logic [3:0] orm  [2];
  logic       shrt [2];

  always @(posedge clk) begin
    lb0_q <= u_if0.jtag_out;
    lb1_q <= u_if1.jtag_out;
  end

  function automatic logic [3:0] fault(input logic [3:0] v, input logic s,
                                       input logic [3:0] am, input logic [3:0] om);
    logic [3:0] r;
    r = v;
    if (s) r[1:0] = {2{v[0] & v[1]}};
    return (r & am) | om;
  endfunction

  assign u_if0.start   = start;
  assign u_if1.start   = start;
  assign u_if0.jtag_in = fault(lb0_q, shrt[0], andm[0], orm[0]);
  assign u_if1.jtag_in = fault(lb1_q, shrt[1], andm[1], orm[1]);

  logic [3:0] o_jout [2];
  logic       o_busy [2];
  logic       o_done [2];
  logic       o_pass [2];
  logic [3:0] o_fail [2];
  logic [3:0] o_jin  [2];
  assign o_jout[0] = u_if0.jtag_out;   assign o_jout[1] = u_if1.jtag_out;
  assign o_busy[0] = u_if0.busy;       assign o_busy[1] = u_if1.busy;
  assign o_done[0] = u_if0.done;       assign o_done[1] = u_if1.done;
  assign o_pass[0] = u_if0.pass;       assign o_pass[1] = u_if1.pass;
  assign o_fail[0] = u_if0.fail_lanes; assign o_fail[1] = u_if1.fail_lanes;
  assign o_jin[0]  = u_if0.jtag_in;    assign o_jin[1]  = u_if1.jtag_in;
`ifdef SELFTEST_ERRCNT_EN
  logic [7:0] o_err [2];
  assign o_err[0] = u_if0.err_count;   assign o_err[1] = u_if1.err_count;
`endif

  task automatic chk(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s[%0d] cycle %0d: got %0h, expected %0h", nm, inst, cyc, act, exp);
    end
  endtask

  function automatic int settle_of(input int i);
    return (i == 0) ? 4 : 2;
  endfunction
  function automatic int passes_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  // A run is described by its position k (cycles since busy rose). Length
  // L = PASSES*10*(S+1)+1; pattern (k/(S+1))%10 is on the lines for k<L-1,
  // sampled when k%(S+1)==S using jtag_in from two cycles earlier.
  bit         act   [2];
  int         kpos  [2];
  logic       m_done[2];
  logic       m_pass[2];
  logic [3:0] m_fail[2];
  int         m_err [2];
  logic       st_h  [4];
  logic [3:0] jh    [2][4];
  logic       p_busy[2];
  logic       p_done[2];
  int         busy_rise[2];
  int         done_cyc [2];
  int         run_len  [2];

  initial begin : model
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 2; i++) begin
          act[i] = 0; kpos[i] = 0; m_done[i] = 0; m_pass[i] = 0;
          m_fail[i] = '0; m_err[i] = 0;
          for (int h = 0; h < 4; h++) jh[i][h] = '0;
        end
        for (int h = 0; h < 4; h++) st_h[h] = 1'b0;
      end else begin
        for (int h = 3; h > 0; h--) begin
          st_h[h] = st_h[h-1];
          jh[0][h] = jh[0][h-1];
          jh[1][h] = jh[1][h-1];
        end
        st_h[0] = start;
        jh[0][0] = o_jin[0];
        jh[1][0] = o_jin[1];
      end

      for (int i = 0; i < 2; i++) begin
        int s, len, idx;
        logic [3:0] exp_out;
        s   = settle_of(i);
        len = passes_of(i) * 10 * (s + 1) + 1;
        idx = (kpos[i] / (s + 1)) % 10;
        exp_out = (act[i] && kpos[i] < len - 1) ? ROM_M[idx] : 4'b0000;
        chk("jtag_out",   i, 32'(o_jout[i]), 32'(exp_out));
        chk("busy",       i, 32'(o_busy[i]), 32'(act[i]));
        chk("done",       i, 32'(o_done[i]), 32'(m_done[i]));
        chk("pass",       i, 32'(o_pass[i]), 32'(m_pass[i]));
        chk("fail_lanes", i, 32'(o_fail[i]), 32'(m_fail[i]));
`ifdef SELFTEST_ERRCNT_EN
        chk("err_count",  i, 32'(o_err[i]),  32'(m_err[i]));
`endif
        // run-length bookkeeping for the literal checks
        if (o_busy[i] && !p_busy[i]) busy_rise[i] = cyc;
        if (o_done[i] && !p_done[i]) begin
          done_cyc[i] = cyc;
          run_len[i]  = cyc - busy_rise[i];
        end
        p_busy[i] = o_busy[i];
        p_done[i] = o_done[i];

        if (rst_n) begin
          if (act[i]) begin
            if (kpos[i] < len - 1 && (kpos[i] % (s + 1)) == s) begin
              logic [3:0] mm;
              mm = jh[i][2] ^ ROM_M[idx];
              m_fail[i] = m_fail[i] | mm;
              if (mm != 0 && m_err[i] < 255) m_err[i]++;
            end
            if (kpos[i] == len - 1) begin
              act[i]    = 0;
              m_done[i] = 1;
              m_pass[i] = (m_fail[i] == 0);
            end else begin
              kpos[i]++;
            end
          end else if (st_h[2] && !st_h[3]) begin
            act[i] = 1; kpos[i] = 0; m_done[i] = 0; m_pass[i] = 0;
            m_fail[i] = '0; m_err[i] = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int w, output int t0);
    tick(1);
    t0 = cyc;
    start = 1'b1;
    tick(w);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    tick(5);
    while ((o_busy[0] || o_busy[1]) && n < budget) begin
      tick(1);
      n++;
    end
    chk("idle_timeout", 0, 32'(o_busy[0] | o_busy[1]), 32'd0);
    tick(2);
  endtask

  task automatic set_ideal();
    for (int i = 0; i < 2; i++) begin
      andm[i] = 4'hF; orm[i] = 4'h0; shrt[i] = 1'b0;
    end
  endtask

  initial begin : stim
    int t0;
    p_busy = '{1'b0, 1'b0};
    p_done = '{1'b0, 1'b0};
    busy_rise = '{0, 0};
    done_cyc  = '{0, 0};
    run_len   = '{0, 0};
    rst_n = 1'b0;
    start = 1'b0;
    set_ideal();
    tick(3);
    chk("rst_jtag_out", 0, 32'(o_jout[0]), 32'h0);
    chk("rst_busy",     0, 32'(o_busy[0]), 32'h0);
    chk("rst_done",     0, 32'(o_done[0]), 32'h0);
    chk("rst_fail",     0, 32'(o_fail[0]), 32'h0);
    rst_n = 1'b1;
    tick(3);

    // Ideal loopback
    pulse_start(2, t0);
    wait_idle(200);
    chk("ideal_runlen", 0, 32'(run_len[0]), 32'd51);
    chk("ideal_donecyc", 0, 32'(done_cyc[0] - t0), 32'd54);
    chk("ideal_pass", 0, 32'(o_pass[0]), 32'd1);
    chk("ideal_fail", 0, 32'(o_fail[0]), 32'h0);
    chk("p3s2_runlen", 1, 32'(run_len[1]), 32'd91);

    // Lane 2 stuck low on inst0, all lanes stuck high on inst1
    andm[0] = 4'b1011;
    orm[1]  = 4'b1111;
    pulse_start(1, t0);
    wait_idle(200);
    chk("stuck2_fail", 0, 32'(o_fail[0]), 32'b0100);
    chk("stuck2_pass", 0, 32'(o_pass[0]), 32'd0);
    chk("stuck1_fail", 1, 32'(o_fail[1]), 32'b1111);
    chk("stuck1_runlen", 1, 32'(run_len[1]), 32'd91);
`ifdef SELFTEST_ERRCNT_EN
    chk("stuck2_err", 0, 32'(o_err[0]), 32'd5);
    chk("stuck1_err", 1, 32'(o_err[1]), 32'd27);
`endif

    // Wired-AND short on lanes 0/1, plus a second start edge mid-run
    set_ideal();
    shrt[0] = 1'b1;
    pulse_start(3, t0);
    tick(20 - 3 - 1);
    start = 1'b1;
    tick(3);
    start = 1'b0;
    wait_idle(200);
    chk("short_fail", 0, 32'(o_fail[0]), 32'b0011);
    chk("short_pass", 0, 32'(o_pass[0]), 32'd0);
    chk("restart_donecyc", 0, 32'(done_cyc[0] - t0), 32'd54);
    chk("restart_runlen", 0, 32'(run_len[0]), 32'd51);

    // Reset mid-run, then a clean run
    set_ideal();
    pulse_start(1, t0);
    while (cyc < t0 + 25) tick(1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 0, 32'(o_busy[0]), 32'd0);
    chk("abort_jtag_out", 0, 32'(o_jout[0]), 32'd0);
    chk("abort_fail", 1, 32'(o_fail[1]), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    pulse_start(2, t0);
    wait_idle(200);
    chk("after_abort_pass", 0, 32'(o_pass[0]), 32'd1);
    chk("after_abort_runlen", 0, 32'(run_len[0]), 32'd51);

    // Randomised faults, pulse widths, re-triggers and resets
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 2; i++) begin
        logic [3:0] s0;
        if ($urandom_range(0, 3) == 0) begin
          andm[i] = 4'hF; orm[i] = 4'h0; shrt[i] = 1'b0;
        end else begin
          s0      = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
          andm[i] = ~s0;
          orm[i]  = 4'($urandom_range(0, 15) & $urandom_range(0, 15)) & ~s0;
          shrt[i] = ($urandom_range(0, 2) == 0);
        end
      end
      tick($urandom_range(1, 6));
      pulse_start($urandom_range(1, 8), t0);
      if ($urandom_range(0, 3) == 0) begin
        tick($urandom_range(2, 40));
        start = 1'b1;
        tick($urandom_range(1, 4));
        start = 1'b0;
      end
      if ($urandom_range(0, 5) == 0) begin
        tick($urandom_range(5, 80));
        rst_n = 1'b0;
        tick($urandom_range(1, 2));
        rst_n = 1'b1;
      end
      wait_idle(300);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_jtag_loopback_tester
`default_nettype wire
